// File: rtl/wb_port_arbiter_if.sv
// Bus bundle for wb_port_arbiter: pipeline write-back request, long-latency result
// stream, hazard scoreboard and the registered register-file write port.
`timescale 1ns/1ps

interface wb_port_arbiter_if;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        ll_issue;
  logic [4:0]  ll_issue_rd;
  logic        ll_valid;
  logic [4:0]  ll_rd;
  logic [31:0] ll_data;
  logic        ll_ready;
  logic        stall_pipe;
  logic [31:0] pending_mask;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  modport slave (
    input  pipe_we, pipe_rd, pipe_data,
    input  ll_issue, ll_issue_rd, ll_valid, ll_rd, ll_data,
    output ll_ready, stall_pipe, pending_mask,
    output rf_we, rf_waddr, rf_wdata
  );

  modport master (
    output pipe_we, pipe_rd, pipe_data,
    output ll_issue, ll_issue_rd, ll_valid, ll_rd, ll_data,
    input  ll_ready, stall_pipe, pending_mask,
    input  rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline priority, buffered long-latency results,
// pending scoreboard and starvation drain. Define WB_LL_BYPASS_EN for empty-FIFO bypass.
`timescale 1ns/1ps

module wb_port_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  wb_port_arbiter_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [SW-1:0] LIMIT    = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {GNT_NONE, GNT_PIPE, GNT_FIFO, GNT_BYPASS} grant_e;

  logic [4:0]    r_mem_rd   [DEPTH];
  logic [31:0]   r_mem_data [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [SW-1:0] r_starve_cnt;
  logic [31:0]   r_pending;
  logic          r_rf_we;
  logic [4:0]    r_rf_waddr;
  logic [31:0]   r_rf_wdata;

  logic          w_empty;
  logic          w_full;
  logic          w_starve;
  logic          w_pipe_req;
  grant_e        w_grant;
  logic          w_push;
  logic          w_pop;
  logic [4:0]    w_wr_rd;
  logic [31:0]   w_wr_data;
  logic [31:0]   w_clr_mask;
  logic [31:0]   w_set_mask;
  logic [SW-1:0] w_starve_nxt;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == FULL_CNT);
  assign w_starve   = !w_empty && (r_starve_cnt == LIMIT);
  assign w_pipe_req = bus.pipe_we && (bus.pipe_rd != 5'd0);

  // Forced drain outranks the pipeline; the pipeline outranks an ordinary drain.
  always_comb begin
    w_grant   = GNT_NONE;
    w_wr_rd   = 5'd0;
    w_wr_data = 32'd0;
    if (w_starve) begin
      w_grant = GNT_FIFO;
    end else if (w_pipe_req) begin
      w_grant = GNT_PIPE;
    end else if (!w_empty) begin
      w_grant = GNT_FIFO;
`ifdef WB_LL_BYPASS_EN
    end else if (bus.ll_valid && (bus.ll_rd != 5'd0)) begin
      w_grant = GNT_BYPASS;
`endif
    end
    case (w_grant)
      GNT_PIPE: begin
        w_wr_rd   = bus.pipe_rd;
        w_wr_data = bus.pipe_data;
      end
      GNT_FIFO: begin
        w_wr_rd   = r_mem_rd[r_rptr];
        w_wr_data = r_mem_data[r_rptr];
      end
      GNT_BYPASS: begin
        w_wr_rd   = bus.ll_rd;
        w_wr_data = bus.ll_data;
      end
      default: begin
        w_wr_rd   = 5'd0;
        w_wr_data = 32'd0;
      end
    endcase
  end

  // ll_ready looks only at full, so a same-cycle pop never makes room for a push.
  assign w_pop  = (w_grant == GNT_FIFO);
  assign w_push = bus.ll_valid && !w_full && (bus.ll_rd != 5'd0) && (w_grant != GNT_BYPASS);

  always_comb begin
    w_clr_mask = 32'd0;
    w_set_mask = 32'd0;
    if ((w_grant == GNT_FIFO) || (w_grant == GNT_BYPASS)) begin
      w_clr_mask = 32'(1) << w_wr_rd;
    end
    if (bus.ll_issue && (bus.ll_issue_rd != 5'd0)) begin
      w_set_mask = 32'(1) << bus.ll_issue_rd;
    end
  end

  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (w_empty || w_pop) begin
      w_starve_nxt = '0;
    end else if ((w_grant == GNT_PIPE) && (r_starve_cnt != LIMIT)) begin
      w_starve_nxt = r_starve_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_rd[r_wptr]   <= bus.ll_rd;
      r_mem_data[r_wptr] <= bus.ll_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_starve_cnt <= '0;
      r_pending    <= 32'd0;
      r_rf_we      <= 1'b0;
      r_rf_waddr   <= 5'd0;
      r_rf_wdata   <= 32'd0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      r_count      <= r_count + CW'(w_push) - CW'(w_pop);
      r_starve_cnt <= w_starve_nxt;
      r_pending    <= (r_pending & ~w_clr_mask) | w_set_mask;
      r_rf_we      <= (w_grant != GNT_NONE);
      if (w_grant != GNT_NONE) begin
        r_rf_waddr <= w_wr_rd;
        r_rf_wdata <= w_wr_data;
      end
    end
  end

  assign bus.ll_ready     = !w_full;
  assign bus.stall_pipe   = w_starve;
  assign bus.pending_mask = r_pending;
  assign bus.rf_we        = r_rf_we;
  assign bus.rf_waddr     = r_rf_waddr;
  assign bus.rf_wdata     = r_rf_wdata;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios then random traffic,
// compared every cycle against a queue-based reference model.
`timescale 1ns/1ps

module tb_wb_port_arbiter;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } result_t;

  logic clk;
  logic rst;
  wb_port_arbiter_if bus ();

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  result_t     fifoQ[$];
  int          starveCnt;
  logic [31:0] pendModel;
  logic        expWe;
  logic [4:0]  expAddr;
  logic [31:0] expData;
  int          checks = 0;
  int          failures = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic pw, input logic [4:0] prd, input logic [31:0] pdata,
                               input logic iss, input logic [4:0] issRd,
                               input logic lv, input logic [4:0] lrd, input logic [31:0] ldata);
    bus.pipe_we     = pw;
    bus.pipe_rd     = prd;
    bus.pipe_data   = pdata;
    bus.ll_issue    = iss;
    bus.ll_issue_rd = issRd;
    bus.ll_valid    = lv;
    bus.ll_rd       = lrd;
    bus.ll_data     = ldata;
  endtask

  task automatic resetModel();
    fifoQ.delete();
    starveCnt = 0;
    pendModel = 32'd0;
    expWe     = 1'b0;
    expAddr   = 5'd0;
    expData   = 32'd0;
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".stall"},   32'(bus.stall_pipe),   32'(fifoQ.size() != 0 && starveCnt >= LIMIT));
    checkOutput({tag, ".ready"},   32'(bus.ll_ready),     32'(fifoQ.size() < DEPTH));
    checkOutput({tag, ".pending"}, bus.pending_mask,      pendModel);
    checkOutput({tag, ".we"},      32'(bus.rf_we),        32'(expWe));
    checkOutput({tag, ".waddr"},   32'(bus.rf_waddr),     32'(expAddr));
    checkOutput({tag, ".wdata"},   bus.rf_wdata,          expData);
  endtask

  // Advance the model by one clock using the rules of the port, not the RTL structure.
  task automatic modelUpdate();
    bit      empty   = (fifoQ.size() == 0);
    bit      full    = (fifoQ.size() >= DEPTH);
    bit      pipeReq = bus.pipe_we && (bus.pipe_rd != 5'd0);
    int      kind    = 0;
    result_t head;
    logic [31:0] clr = 32'd0;
    logic [31:0] set = 32'd0;
    if (!empty && starveCnt >= LIMIT) kind = 2;
    else if (pipeReq)                 kind = 1;
    else if (!empty)                  kind = 2;
`ifdef WB_LL_BYPASS_EN
    else if (bus.ll_valid && bus.ll_rd != 5'd0) kind = 3;
`endif
    expWe = (kind != 0);
    if (kind == 1) begin
      expAddr = bus.pipe_rd;
      expData = bus.pipe_data;
    end else if (kind == 2) begin
      head    = fifoQ.pop_front();
      expAddr = head.rd;
      expData = head.data;
      clr[head.rd] = 1'b1;
    end else if (kind == 3) begin
      expAddr = bus.ll_rd;
      expData = bus.ll_data;
      clr[bus.ll_rd] = 1'b1;
    end
    if (bus.ll_issue && bus.ll_issue_rd != 5'd0) begin
      assert (!pendModel[bus.ll_issue_rd]) else begin
        failures++;
        $error("[TB] FAIL issue_to_pending observed=rd%0d expected=not_pending", bus.ll_issue_rd);
      end
      set[bus.ll_issue_rd] = 1'b1;
    end
    pendModel = (pendModel & ~clr) | set;
    if (empty || kind == 2)  starveCnt = 0;
    else if (kind == 1)      starveCnt = (starveCnt + 1 > LIMIT) ? LIMIT : starveCnt + 1;
    if (bus.ll_valid && !full && bus.ll_rd != 5'd0 && kind != 3)
      fifoQ.push_back('{rd: bus.ll_rd, data: bus.ll_data});
  endtask

  task automatic step(input string tag);
    #2;
    checkAll(tag);
    modelUpdate();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx;
    int guard;
    logic [4:0] r;
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    resetModel();
    #12;
    checkAll("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Pipeline only, then a write to x0 which must be ignored.
    applyStimulus(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    step("pipe5");
    checkOutput("pipe5.we_dir",   32'(bus.rf_we),    32'd1);
    checkOutput("pipe5.addr_dir", 32'(bus.rf_waddr), 32'd5);
    checkOutput("pipe5.data_dir", bus.rf_wdata,      32'hDEADBEEF);
    applyStimulus(1, 5'd0, 32'h12345678, 0, 0, 0, 0, 0);
    step("pipe0");
    checkOutput("pipe0.we_dir",    32'(bus.rf_we),      32'd0);
    checkOutput("pipe0.stall_dir", 32'(bus.stall_pipe), 32'd0);

    // FIFO fill with the pipe idle: issue 1..4, then return results in order.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(0, 0, 0, 1, 5'(i), 0, 0, 0);
      step("fill.issue");
    end
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 1, 5'(i), 32'(i * 32'h11));
      step("fill.push");
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("fill.drain");
    checkOutput("fill.last_addr", 32'(bus.rf_waddr), 32'd4);
    checkOutput("fill.last_data", bus.rf_wdata,      32'h44);

    // Back-pressure: pipe busy, source holds each result until accepted.
    idx = 0;
    guard = 0;
    while (idx < 5 && guard < 60) begin
      bit ready = (fifoQ.size() < DEPTH);
      applyStimulus(1, 5'(8 + (guard % 4)), 32'hA000_0000 + guard, 0, 0,
                    1, 5'(20 + idx), 32'hB000_0000 + idx);
      step("bp");
      if (ready) idx++;
      guard++;
    end
    checkOutput("bp.all_accepted", idx, 5);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step("bp.drain");

    // Starvation: one buffered result, pipe requesting every cycle.
    applyStimulus(1, 5'd3, 32'h3000, 0, 0, 1, 5'd15, 32'h0F0F_0F0F);
    step("starve.push");
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1, 5'(16 + (i % 8)), 32'h5000 + i, 0, 0, 0, 0, 0);
      step("starve");
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    step("starve.idle");

    // Scoreboard: issue 7, return its result, issue 9 in the grant cycle.
    applyStimulus(0, 0, 0, 1, 5'd7, 0, 0, 0);
    step("sb.issue7");
    checkOutput("sb.pend80", bus.pending_mask, 32'h0000_0080);
    applyStimulus(0, 0, 0, 0, 0, 1, 5'd7, 32'h7777_7777);
    step("sb.push7");
    applyStimulus(0, 0, 0, 1, 5'd9, 0, 0, 0);
    step("sb.issue9");
    checkOutput("sb.pend200", bus.pending_mask, 32'h0000_0200);
    checkOutput("sb.addr7",   32'(bus.rf_waddr), 32'd7);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    step("sb.idle");

    // Reset mid-drain with three results queued and the pipe writing.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 5'd2, 32'hC0 + i, 1, 5'(10 + i), 0, 0, 0);
      step("rst.issue");
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 5'd2, 32'hD0 + i, 0, 0, 1, 5'(10 + i), 32'hE0 + i);
      step("rst.push");
    end
    applyStimulus(1, 5'd2, 32'hD9, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst.we_async",   32'(bus.rf_we),    32'd0);
    checkOutput("rst.pend_async", bus.pending_mask,  32'd0);
    checkOutput("rst.ready",      32'(bus.ll_ready), 32'd1);
    resetModel();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step("rst.after");

    // Random traffic; issues only target registers with nothing outstanding.
    for (int c = 0; c < 400; c++) begin
      logic pw = ($urandom_range(0, 9) < 7);
      logic iss;
      r   = 5'($urandom_range(0, 31));
      iss = ($urandom_range(0, 3) == 0) && !pendModel[r];
      applyStimulus(pw, 5'($urandom_range(0, 31)), $urandom(), iss, r,
                    ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)), $urandom());
      step("rand");
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step("rand.drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Owns the single register-file write port behind the write-back mux.
- Shares the port between in-order pipeline write-back (priority) and a long-latency unit (divider / slow load return), whose results are buffered in a small FIFO.
- Keeps a per-register pending scoreboard for the hazard unit.
- Forces the pipeline to yield one cycle when buffered results starve.

Parameters:
DEPTH, 4, long-latency result FIFO entries (power of 2, >=2)
STARVE_LIMIT, 8, consecutive pipeline grants with FIFO non-empty before a forced drain (>=1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
pipe_we  in  1  MEM/WB stage wants to write the register file
pipe_rd  in  5  MEM/WB destination register
pipe_data  in  32  write-back mux result
ll_issue  in  1  long-latency op issued this cycle
ll_issue_rd  in  5  destination of issued op
ll_valid  in  1  long-latency result valid
ll_rd  in  5  result destination register
ll_data  in  32  result data
ll_ready  out  1  FIFO can accept a result (= !full)
stall_pipe  out  1  pipeline write-back refused this cycle; hold MEM/WB
pending_mask  out  32  bit r set = result for register r outstanding
rf_we  out  1  register-file write enable (registered)
rf_waddr  out  5  register-file write address (registered)
rf_wdata  out  32  register-file write data (registered)

Behaviour:
- Reset: FIFO empty, starve_cnt=0, pending_mask=0, rf_we=0, rf_waddr=0, rf_wdata=0, stall_pipe=0, ll_ready=1.
- Push: occurs when ll_valid && ll_ready. ll_ready depends only on full; a pop in the same cycle does not free a slot for the push.
- ll_rd=0: accepted, not stored, no pending change.
- Grant priority each cycle:
  - (a) FIFO non-empty and starve_cnt==STARVE_LIMIT: FIFO head granted, stall_pipe=1, pipe request ignored and must be re-presented.
  - (b) else pipe_we && pipe_rd!=0: pipeline granted.
  - (c) else FIFO non-empty: head granted, popped.
  - (d) else: no grant.
- pipe_we with pipe_rd=0: never granted, never stalled, counts as no request.
- stall_pipe is a combinational function of registered state only (starve_cnt, FIFO empty); it never depends on pipe_we.
- Latency: a granted write appears on rf_* at the next rising edge; rf_we=0 on cycles with no grant. rf_waddr/rf_wdata hold their last values when rf_we=0.
- starve_cnt:
  - increments (saturating at STARVE_LIMIT) on a pipeline grant while the FIFO is non-empty;
  - clears on any FIFO grant or whenever the FIFO is empty.
- FIFO: circular with wrap-around pointers and a count. Full at count==DEPTH. Simultaneous push and pop when non-full keeps the count unchanged.
- pending_mask:
  - bit set on ll_issue with ll_issue_rd!=0;
  - bit cleared on the cycle the matching FIFO entry is granted.
  - Issue to an already-pending register is illegal: the hazard unit must stall on pending_mask. The bench asserts this never occurs.
  - Set and clear of different bits in one cycle both take effect.
- Ordering: FIFO results retire in push order. Pipeline and FIFO writes retire in grant order.
- Reset mid-operation: FIFO contents, pending bits and any in-flight rf_* write are discarded immediately; rf_we drops asynchronously.

Optional Feature:
WB_LL_BYPASS_EN
- Defined: when the FIFO is empty, the pipeline is not granted and ll_valid && ll_rd!=0, the incoming result is granted directly and written at the next edge (1-cycle push-to-write latency). It is not stored, and its pending bit clears that cycle.
- Undefined: every result passes through the FIFO, so the earliest rf_we is 2 cycles after push.

Test Plan:
- Pipeline only: pipe_we=1, pipe_rd=5, pipe_data=0xDEADBEEF -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF. pipe_rd=0 -> rf_we=0, stall_pipe=0.
- FIFO fill: 4 ll results (rd 1..4, data 0x11..0x44) with pipe idle and bypass off -> written in order 1,2,3,4. ll_ready stays 1 because pops keep pace.
- Back-pressure: pipe_we=1 every cycle, push 5 results -> ll_ready=0 after 4 accepted. The fifth is held by the source until a slot frees.
- Starvation: FIFO holds 1 entry, pipe_we=1 continuously, STARVE_LIMIT=8 -> 8 pipeline writes, then stall_pipe=1 for exactly one cycle with the FIFO entry written, then pipeline resumes.
- Scoreboard: ll_issue rd=7 -> pending_mask=0x80. Result for rd 7 pushed and granted -> bit 7 clears in the grant cycle. A simultaneous issue of rd=9 sets bit 9.
- Reset mid-drain: assert rst with 3 entries queued and rf_we=1 -> rf_we=0 and pending_mask=0 immediately; after release, no stale writes appear.
